// File: rtl/uart_mem_loader.sv
// UART-fed boot loader: parses SYNC/ADDR/LEN/payload/CHK frames and writes the
// payload into RAM over the shared memory bus while holding the CPU off it.

`ifndef STORE_W
`define STORE_W 3'b010
`endif
`ifndef STORE_B
`define STORE_B 3'b000
`endif

module uart_mem_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 100000,
    parameter int unsigned TO_W      = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wd,
    output logic        bus_we,
    output logic [2:0]  bus_mem_ctrl,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_LEN   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_CHK   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]      state, state_nxt;
    logic [31:0]     addr;
    logic [15:0]     rem;
    logic [1:0]      cnt;
    logic [23:0]     wbuf;
    logic [7:0]      acc_x;
    logic [TO_W-1:0] to_cnt;

    logic        take, counting, to_hit, tail;
    logic        sync_hit, err_set, wr_word, wr_byte;
    logic [15:0] len_full;

    assign take     = in_valid & in_ready;
    assign counting = (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_DATA) || (state == S_CHK);
    assign to_hit   = counting && !take && (to_cnt == TO_W'(TIMEOUT - 1));
    // Below a word boundary with fewer than 4 bytes left, bytes go out singly
    assign tail     = (cnt == 2'd0) && (rem < 16'd4);
    assign len_full = {in_data, rem[15:8]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle strobes
    always_comb begin
        state_nxt = state;
        sync_hit  = 1'b0;
        err_set   = 1'b0;
        wr_word   = 1'b0;
        wr_byte   = 1'b0;
        case (state)
            S_IDLE: begin
                if (take && in_data == SYNC_BYTE) begin
                    sync_hit  = 1'b1;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (take && cnt == 2'd3) begin
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (take && cnt == 2'd1) begin
                    if (addr[1:0] != 2'b00) begin
                        err_set   = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (len_full == 16'd0) begin
                        state_nxt = S_CHK;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    if (tail) begin
                        wr_byte   = 1'b1;
                        state_nxt = S_WRITE;
                    end else if (cnt == 2'd3) begin
                        wr_word   = 1'b1;
                        state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                state_nxt = (rem != 16'd0) ? S_DATA : S_CHK;
            end
            S_CHK: begin
                if (take) begin
                    err_set   = (in_data != acc_x);
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (to_hit) begin
            err_set   = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready     <= 1'b1;
            bus_we       <= 1'b0;
            bus_addr     <= 32'd0;
            bus_wd       <= 32'd0;
            bus_mem_ctrl <= `STORE_W;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            in_ready <= !((state_nxt == S_WRITE) || (state_nxt == S_DONE));
            busy     <= (state_nxt != S_IDLE);
            cpu_hold <= !((state_nxt == S_IDLE) || (state_nxt == S_DONE));
            done     <= (state_nxt == S_DONE) && !err_set && !error;
            bus_we   <= wr_word | wr_byte;
            if (wr_word) begin
                bus_addr     <= addr;
                bus_wd       <= {in_data, wbuf};
                bus_mem_ctrl <= `STORE_W;
            end else if (wr_byte) begin
                bus_addr     <= addr;
                bus_wd       <= {24'd0, in_data};
                bus_mem_ctrl <= `STORE_B;
            end
            if (err_set) begin
                error <= 1'b1;
            end else if (sync_hit) begin
                error <= 1'b0;
            end
        end
    end

    // Frame datapath: address/length shift-in, word assembly, checksum, timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= 32'd0;
            rem    <= 16'd0;
            cnt    <= 2'd0;
            wbuf   <= 24'd0;
            acc_x  <= 8'd0;
            to_cnt <= '0;
        end else begin
            to_cnt <= (take || !counting) ? '0 : to_cnt + TO_W'(1);
            if (sync_hit) begin
                cnt   <= 2'd0;
                acc_x <= 8'd0;
            end
            if (take && state == S_ADDR) begin
                addr <= {in_data, addr[31:8]};
                cnt  <= cnt + 2'd1;
            end
            if (take && state == S_LEN) begin
                rem <= len_full;
                cnt <= (cnt == 2'd1) ? 2'd0 : cnt + 2'd1;
            end
            if (take && state == S_DATA) begin
                acc_x <= acc_x ^ in_data;
                rem   <= rem - 16'd1;
                if (!tail) begin
                    case (cnt)
                        2'd0:    wbuf[7:0]   <= in_data;
                        2'd1:    wbuf[15:8]  <= in_data;
                        2'd2:    wbuf[23:16] <= in_data;
                        default: wbuf        <= wbuf;
                    endcase
                    cnt <= cnt + 2'd1;
                end
            end
            if (wr_word) begin
                addr <= addr + 32'd4;
            end else if (wr_byte) begin
                addr <= addr + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader: frames are modelled as expected bus
// writes/done pulses in a queue, and a monitor matches them against the bus.

`ifndef STORE_W
`define STORE_W 3'b010
`endif
`ifndef STORE_B
`define STORE_B 3'b000
`endif

module tb_uart_mem_loader;

    localparam int unsigned TIMEOUT = 300;
    localparam int unsigned TO_W    = 17;
    localparam logic [7:0]  SYNC    = 8'hA5;
    localparam logic [2:0]  ST_W    = `STORE_W;
    localparam logic [2:0]  ST_B    = `STORE_B;

    logic        clk, rst;
    logic [7:0]  in_data;
    logic        in_valid, in_ready;
    logic [31:0] bus_addr, bus_wd;
    logic        bus_we;
    logic [2:0]  bus_mem_ctrl;
    logic        cpu_hold, busy, done, error;

    uart_mem_loader #(.SYNC_BYTE(SYNC), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .bus_addr     (bus_addr),
        .bus_wd       (bus_wd),
        .bus_we       (bus_we),
        .bus_mem_ctrl (bus_mem_ctrl),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  ctrl;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pay[$];
    int         checks = 0;
    int         errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every bus write or done pulse must match the next expected event
    ev_t mon_ev;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_we) begin
                chk("we_cpu_hold", 32'(cpu_hold), 32'(1));
                chk("we_in_ready_low", 32'(in_ready), 32'(0));
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_write: got addr 0x%08h wd 0x%08h expected no write",
                             bus_addr, bus_wd);
                end else begin
                    mon_ev = exp_q.pop_front();
                    chk("write_addr", bus_addr, mon_ev.addr);
                    chk("write_wd", bus_wd, mon_ev.wd);
                    chk("write_ctrl", 32'(bus_mem_ctrl), 32'(mon_ev.ctrl));
                end
            end
            if (done) begin
                chk("done_cpu_hold", 32'(cpu_hold), 32'(0));
                chk("done_error", 32'(error), 32'(0));
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1 expected pending events %0d",
                             exp_q.size());
                end else begin
                    mon_ev = exp_q.pop_front();
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is accepted
    task automatic send_byte(input logic [7:0] b);
        int w;
        w        = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model the frame (payload in pay) as expected events, then drive it
    task automatic send_frame(input logic [31:0] a, input bit bad_chk, input int ngarb,
                              input int maxgap, input int big_gap);
        logic [7:0] x;
        logic [7:0] b;
        ev_t        e;
        int         len;
        int         i;
        x   = 8'h00;
        len = pay.size();
        foreach (pay[k]) x ^= pay[k];
        if (a[1:0] == 2'b00) begin
            i = 0;
            while (len - i >= 4) begin
                e.is_done = 1'b0;
                e.addr    = a + 32'(i);
                e.wd      = {pay[i+3], pay[i+2], pay[i+1], pay[i]};
                e.ctrl    = ST_W;
                exp_q.push_back(e);
                i += 4;
            end
            while (i < len) begin
                e.is_done = 1'b0;
                e.addr    = a + 32'(i);
                e.wd      = {24'd0, pay[i]};
                e.ctrl    = ST_B;
                exp_q.push_back(e);
                i++;
            end
            if (!bad_chk) begin
                e.is_done = 1'b1;
                e.addr    = 32'd0;
                e.wd      = 32'd0;
                e.ctrl    = 3'd0;
                exp_q.push_back(e);
            end
        end
        repeat (ngarb) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h00;
            send_byte(b);
            idle($urandom_range(0, maxgap));
        end
        send_byte(SYNC);
        chk("sync_cpu_hold", 32'(cpu_hold), 32'(1));
        chk("sync_busy", 32'(busy), 32'(1));
        chk("sync_error_clear", 32'(error), 32'(0));
        for (int k = 0; k < 4; k++) begin
            send_byte(a[8*k +: 8]);
            if (k == 1) idle(big_gap);
        end
        send_byte(8'(len));
        send_byte(8'(len >> 8));
        if (a[1:0] != 2'b00) begin
            idle(3);
            chk("misalign_error", 32'(error), 32'(1));
            chk("misalign_busy", 32'(busy), 32'(0));
            chk("misalign_cpu_hold", 32'(cpu_hold), 32'(0));
            chk("misalign_no_write", exp_q.size(), 0);
            return;
        end
        foreach (pay[k]) begin
            idle($urandom_range(0, maxgap));
            send_byte(pay[k]);
        end
        send_byte(bad_chk ? (x ^ 8'h44) : x);
        idle(3);
        chk("frame_error", 32'(error), 32'(bad_chk));
        chk("frame_busy", 32'(busy), 32'(0));
        chk("frame_cpu_hold", 32'(cpu_hold), 32'(0));
        chk("frame_events_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before 2 ms");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        idle(3);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_bus_we", 32'(bus_we), 32'(0));
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wd", bus_wd, 32'd0);
        chk("rst_mem_ctrl", 32'(bus_mem_ctrl), 32'(ST_W));
        chk("rst_cpu_hold", 32'(cpu_hold), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_error", 32'(error), 32'(0));
        rst = 1'b0;
        idle(2);

        // Single word, good checksum
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(32'h0000_0100, 1'b0, 0, 0, 0);
        // Word followed by two tail bytes
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_frame(32'h0000_0200, 1'b0, 0, 1, 0);
        // Bad checksum (sends 00): write still lands, no done
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(32'h0000_0100, 1'b1, 0, 0, 0);
        // Misaligned address
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(32'h0000_0102, 1'b0, 0, 0, 0);
        // Zero-length frame
        pay = {};
        send_frame(32'h0000_0800, 1'b0, 0, 0, 0);
        // Address wraps past 2^32
        pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        send_frame(32'hFFFF_FFFC, 1'b0, 0, 0, 0);
        // Long but legal gap between bytes
        pay = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h9E};
        send_frame(32'h0000_0C00, 1'b0, 2, 1, int'(TIMEOUT) - 20);

        // Timeout after 2 of 4 payload bytes
        send_byte(SYNC);
        send_byte(8'h00); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h04); send_byte(8'h00);
        send_byte(8'hDE); send_byte(8'hAD);
        idle(int'(TIMEOUT) + 20);
        chk("timeout_error", 32'(error), 32'(1));
        chk("timeout_busy", 32'(busy), 32'(0));
        chk("timeout_cpu_hold", 32'(cpu_hold), 32'(0));
        chk("timeout_in_ready", 32'(in_ready), 32'(1));
        pay = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_frame(32'h0000_0300, 1'b0, 0, 0, 0);

        // Garbage before SYNC, then reset in the middle of DATA
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
        chk("garbage_busy", 32'(busy), 32'(0));
        send_byte(SYNC);
        send_byte(8'h00); send_byte(8'h04); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h08); send_byte(8'h00);
        send_byte(8'h77); send_byte(8'h88);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_bus_we", 32'(bus_we), 32'(0));
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_in_ready", 32'(in_ready), 32'(1));
        rst = 1'b0;
        idle(1);
        pay = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        send_frame(32'h0000_0400, 1'b0, 0, 0, 0);

        // Randomized frames
        for (int n = 0; n < 25; n++) begin
            r = $urandom;
            a = ($urandom_range(0, 7) == 0) ? (r | 32'd1) : (r & 32'hFFFF_FFFC);
            pay = {};
            repeat ($urandom_range(0, 11)) pay.push_back(8'($urandom));
            send_frame(a, ($urandom_range(0, 4) == 0), $urandom_range(0, 3),
                       $urandom_range(0, 2), 0);
        end

        idle(5);
        chk("queue_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Memory-bus initiator that drives the same address/wd/we/mem_ctrl interface the CPU drives into the IO/RAM datapath.
- Consumes a byte stream from the UART receive side and parses a framed load command.
- Writes the payload into RAM, assembling full words as STORE_W and writing tail bytes as STORE_B.
- Holds the CPU off the bus while a frame is in progress. Used as the boot/program loader.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker; any other byte in IDLE is discarded.
- TIMEOUT, 100000, idle cycles allowed between bytes inside a frame before abort.
- TO_W, 17, counter width for TIMEOUT; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_data  in  8  received byte
- in_valid  in  1  in_data valid; byte accepted on cycle where in_valid & in_ready
- in_ready  out  1  loader can accept a byte
- bus_addr  out  32  byte address to IO/RAM datapath
- bus_wd  out  32  write data; a byte store carries the byte in [7:0]
- bus_we  out  1  write strobe, one cycle per store
- bus_mem_ctrl  out  3  `STORE_W for word writes, `STORE_B for byte writes
- cpu_hold  out  1  1 while a frame is active; CPU stalls and bus mux selects loader
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on successful frame completion
- error  out  1  sticky; set on bad checksum, misaligned address or timeout; cleared by rst or next SYNC_BYTE

Behaviour:
- Reset values: in_ready=1, bus_we=0, bus_addr=0, bus_wd=0, bus_mem_ctrl=`STORE_W, cpu_hold=0, busy=0, done=0, error=0, state=IDLE.
- Frame format: SYNC, ADDR0..ADDR3 (little-endian), LEN0..LEN1 (little-endian byte count), LEN payload bytes, CHK. CHK is the XOR of all payload bytes.
- States: IDLE, ADDR, LEN, DATA, WRITE, CHK, DONE.
- IDLE:
  - Accepted SYNC_BYTE -> ADDR; clears error and XOR accumulator; cpu_hold=1 from the next cycle.
  - Any other byte is dropped.
- ADDR: collect 4 bytes, then go to LEN.
- LEN: collect 2 bytes. After LEN1:
  - addr[1:0] != 0 -> set error, go to IDLE.
  - LEN == 0 -> go to CHK.
  - Otherwise -> go to DATA.
- DATA:
  - Each accepted byte is shifted into the word buffer at lane (byte_cnt mod 4) and XORed into the accumulator; the remaining count is decremented.
  - When a 4th byte completes a word -> WRITE with `STORE_W at the current word address.
  - When the remaining count is <4 at a word boundary, each tail byte goes directly to WRITE as `STORE_B at addr+offset, data in [7:0].
- WRITE:
  - Exactly one cycle: bus_we=1; in_ready=0.
  - bus_addr and bus_wd are stable for the whole cycle.
  - Address advances by 4 (word) or 1 (byte).
  - Next state: DATA if bytes remain, else CHK.
- CHK: the accepted byte is compared with the accumulator; a mismatch sets error. Then -> DONE.
- DONE: for one cycle, done=1 only if error=0 and cpu_hold=0 (released this cycle). Then -> IDLE.
- Throughput: at most one store per 4 accepted bytes on the word path. in_ready is low only in WRITE and DONE.
- Timeout:
  - Counter resets on every accepted byte; it counts only in ADDR/LEN/DATA/CHK.
  - Reaching TIMEOUT sets error and returns to IDLE. Writes already issued are not undone.
- bus_we is never asserted outside WRITE. The 32-bit address wraps modulo 2^32 with no check.
- LEN is max 65535; the remaining-count register is 16 bits.
- rst mid-frame: next cycle state=IDLE, bus_we=0, cpu_hold=0. A partial word in the buffer is discarded.

Test Plan:
- Frame A5, 00 01 00 00, 04 00, 11 22 33 44, chk 44 -> one bus_we cycle with addr=0x00000100, wd=0x44332211, `STORE_W; done pulses; error=0; cpu_hold high from the cycle after SYNC until DONE.
- LEN=6 at addr 0x200, payload 01..06, chk 07 -> word 0x04030201 @0x200 `STORE_W, then bytes 05 @0x204 and 06 @0x205 as `STORE_B with wd[7:0]=byte; done.
- Same frame as scenario 1 with chk 00 -> the write still occurs; error=1; done stays 0; state returns to IDLE.
- Address 0x00000102 -> error after LEN1; no bus_we at any time; cpu_hold drops.
- Byte gap > TIMEOUT after 2 of 4 payload bytes -> error=1, no write issued; the next A5 clears error.
- Garbage bytes 00 FF 12 before SYNC are ignored; assert rst during DATA -> bus_we=0, cpu_hold=0, busy=0 on the following cycle.
